// File: rtl/frame_commit_controller.sv
// Holds one core datagram in a shadow register and commits it to the display copy at vsync start.
// Latency: commit lands 2 clk edges after vsync_in is first sampled active; ready is registered.
// Backpressure: datagram_ready drops while the shadow is full and rises on the clk of its commit.
module frame_commit_controller #(
    parameter int MSG_W        = 32,
    parameter int STATE_W      = 8,
    parameter int BLANK_FRAMES = 2,
    parameter bit VSYNC_ACTIVE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [MSG_W-1:0] datagram_in,
    input  logic             datagram_valid,
    output logic             datagram_ready,
    input  logic             vsync_in,
    output logic [MSG_W-1:0] datagram_out,
    output logic             blank,
    output logic             frame_commit,
    output logic [15:0]      frame_cnt,
    output logic [7:0]       stale_cnt
);

    typedef enum logic {SHOW, BLANK} state_t;

    localparam int              CNT_W      = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES + 1) : 1;
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_FRAMES);
    localparam logic            VS_IDLE    = ~VSYNC_ACTIVE;

    logic             vs_s1, vs_s2, vs_s3;
    logic             vs_start;
    logic [MSG_W-1:0] shadow;
    logic             shadow_full;
    logic             shadow_full_nxt;
    logic             accept;
    logic             commit;
    logic             scene_change;
    state_t           state, state_nxt;
    logic [CNT_W-1:0] blank_cnt, blank_cnt_nxt;

    // vsync_in comes from the pixel clock domain; s3 is only used for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vs_s1 <= VS_IDLE;
            vs_s2 <= VS_IDLE;
            vs_s3 <= VS_IDLE;
        end else begin
            vs_s1 <= vsync_in;
            vs_s2 <= vs_s1;
            vs_s3 <= vs_s2;
        end
    end

    assign vs_start     = (vs_s2 == VSYNC_ACTIVE) && (vs_s3 != VSYNC_ACTIVE);
    assign accept       = datagram_valid && datagram_ready;
    assign commit       = vs_start && shadow_full;
    assign scene_change = commit && (shadow[STATE_W-1:0] != datagram_out[STATE_W-1:0]);

    // accept and commit are exclusive: ready is the registered complement of shadow_full.
    always_comb begin
        shadow_full_nxt = shadow_full;
        if (commit)
            shadow_full_nxt = 1'b0;
        else if (accept)
            shadow_full_nxt = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow         <= '0;
            shadow_full    <= 1'b0;
            datagram_ready <= 1'b0;
            datagram_out   <= '0;
            frame_commit   <= 1'b0;
            frame_cnt      <= '0;
            stale_cnt      <= '0;
        end else begin
            shadow_full    <= shadow_full_nxt;
            datagram_ready <= !shadow_full_nxt;
            frame_commit   <= commit;
            if (accept)
                shadow <= datagram_in;
            if (vs_start) begin
                frame_cnt <= frame_cnt + 16'd1;
                if (shadow_full) begin
                    datagram_out <= shadow;
                    stale_cnt    <= '0;
                end else if (stale_cnt != 8'hFF) begin
                    stale_cnt <= stale_cnt + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= SHOW;
            blank_cnt <= '0;
            blank     <= 1'b0;
        end else begin
            state     <= state_nxt;
            blank_cnt <= blank_cnt_nxt;
            blank     <= (state_nxt == BLANK);
        end
    end

    always_comb begin
        state_nxt     = state;
        blank_cnt_nxt = blank_cnt;
        case (state)
            SHOW: begin
                if (scene_change && (BLANK_FRAMES > 0)) begin
                    state_nxt     = BLANK;
                    blank_cnt_nxt = BLANK_LOAD;
                end
            end
            BLANK: begin
                if (vs_start) begin
                    if (scene_change) begin
                        blank_cnt_nxt = BLANK_LOAD;
                    end else if (blank_cnt <= CNT_W'(1)) begin
                        blank_cnt_nxt = '0;
                        state_nxt     = SHOW;
                    end else begin
                        blank_cnt_nxt = blank_cnt - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_nxt     = SHOW;
                blank_cnt_nxt = '0;
            end
        endcase
    end

endmodule
